mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sub-word load/store sequencer directly upstream of the memory stage. It drives that stage's Mem_WrEn, ALU_MEM_Addr and MEM_DataIn inputs, and consumes its MEM_DataOut.
- The memory is word-wide only, so this block performs:
  - byte/halfword stores as read-modify-write;
  - byte/halfword loads as lane extraction with sign or zero extension.
- Single outstanding request with a ready/done handshake toward the pipeline control.

Parameters:
- MEM_RD_LAT, 1, cycles from address driven to MEM_DataOut valid (synchronous read); legal values 1..3.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request strobe; sampled only while req_ready=1
- req_ready  out  1  high when idle and able to accept a request
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=halfword, 10=word; 11 is treated as word
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data, right-justified
- done  out  1  one-cycle pulse when the request completes
- rdata  out  32  load result; valid when done=1, held until the next done
- err  out  1  misalignment flag; valid with done
- Mem_WrEn  out  1  memory write enable
- ALU_MEM_Addr  out  32  memory byte address, word-aligned ({addr[31:2],2'b00})
- MEM_DataIn  out  32  memory write data
- MEM_DataOut  in  32  memory read data

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, req_ready=1, done=0, err=0, rdata=0, Mem_WrEn=0, ALU_MEM_Addr=0, MEM_DataIn=0.
- Byte order is little-endian. Byte lane = addr[1:0]; halfword lane = addr[1].
- Request capture: on accept (req_valid & req_ready), all request fields are registered. Inputs are ignored until the next IDLE.
- States: IDLE, RD_WAIT, WRITE, DONE.
  - IDLE, on accept:
    - word store → WRITE
    - misaligned access → DONE (no memory access, err=1)
    - otherwise → RD_WAIT
  - RD_WAIT:
    - ALU_MEM_Addr held.
    - Counter counts MEM_RD_LAT cycles; then MEM_DataOut is captured.
    - Loads: extracted and extended result → rdata, then → DONE.
    - Sub-word stores: the selected lane(s) of the captured word are replaced with req_wdata[7:0] or [15:0], then → WRITE.
  - WRITE:
    - Mem_WrEn=1 for exactly one cycle.
    - MEM_DataIn = merged word (or req_wdata for a word store).
    - → DONE.
  - DONE: done=1 for one cycle, then → IDLE. req_ready returns high in IDLE.
- Latency, accept edge to done pulse:
  - word store: 2 cycles
  - load: MEM_RD_LAT+1 cycles
  - sub-word store: MEM_RD_LAT+2 cycles
  - misaligned: 1 cycle
- Mem_WrEn is asserted only in WRITE. rdata is updated only for loads and is unchanged by stores.
- Extension:
  - byte load: {24{unsigned?0:b[7]},b}
  - halfword load: {16{unsigned?0:h[15]},h}
- err: cleared on every accept; set only by a misaligned request.
- Reset mid-operation: returns to IDLE immediately. Any pending WRITE is abandoned, so Mem_WrEn is 0 in the cycle after rst is sampled. done is not pulsed.
- Back-to-back: a request may be presented in the same cycle req_ready rises. It is accepted and goes straight out of IDLE with no bubble.

Optional Feature:
- MISALIGN_TRAP_EN.
- Defined:
  - halfword with addr[0]=1, or word with addr[1:0]≠0, is misaligned;
  - the request completes via DONE with err=1, no memory access, rdata unchanged.
- Undefined:
  - err is tied 0;
  - misaligned halfwords use lane addr[1] and misaligned words use addr[31:2], with the low address bits ignored;
  - all requests go through the normal path.

Test Plan:
- Reset, then word store addr=0x10, wdata=0xDEADBEEF → req_ready=1 after reset. Mem_WrEn high exactly one cycle with ALU_MEM_Addr=0x10 and MEM_DataIn=0xDEADBEEF. done 2 cycles after accept.
- With mem[0x10]=0xDEADBEEF: byte store addr=0x12, wdata=0x55 → read then write of 0xDE55BEEF; done at MEM_RD_LAT+2.
- With mem[0x10]=0xDE55BEEF:
  - byte load addr=0x13, signed → rdata=0xFFFFFFDE
  - byte load addr=0x13, unsigned → rdata=0x000000DE
  - halfword load addr=0x10, signed → rdata=0xFFFFBEEF
- Halfword store addr=0x11:
  - MISALIGN_TRAP_EN defined → done+err=1 after 1 cycle, Mem_WrEn never asserted.
  - undefined → lane 0 written, err=0.
- rst asserted during RD_WAIT of a byte store → no Mem_WrEn, no done. req_ready=1 the next cycle and mem unchanged.
- Two loads back-to-back with req_valid held high → second accepted the cycle req_ready rises. Two done pulses with correct rdata each.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Sub-word load/store sequencer in front of a word-wide memory: read-modify-write for
// byte/halfword stores, lane extraction with extension for loads. Optional macro: MISALIGN_TRAP_EN.
module mem_access_ctrl #(
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        Mem_WrEn,
  output logic [31:0] ALU_MEM_Addr,
  output logic [31:0] MEM_DataIn,
  input  logic [31:0] MEM_DataOut
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  // Read data is taken on the MEM_RD_LAT-th edge after the address register loads.
  localparam logic [1:0] LAST_CNT = 2'(MEM_RD_LAT - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;

  logic        accept;
  logic        misaligned;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign accept = req_valid & ready_q;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign rd_byte = MEM_DataOut[{lane_q, 3'b000} +: 8];
  assign rd_half = MEM_DataOut[{lane_q[1], 4'b0000} +: 16];

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    load_val = MEM_DataOut;
    merged   = MEM_DataOut;
    unique case (size_q)
      SZ_BYTE: begin
        load_val = {{24{~unsigned_q & rd_byte[7]}}, rd_byte};
        merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_HALF: begin
        load_val = {{16{~unsigned_q & rd_half[15]}}, rd_half};
        merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: begin
        load_val = MEM_DataOut;
        merged   = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    lane_d     = lane_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    din_d      = din_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d       = req_we;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          lane_d     = req_addr[1:0];
          wdata_d    = req_wdata;
          err_d      = misaligned;
          cnt_d      = 2'd0;
          if (misaligned) begin
            state_d = ST_DONE;
          end else begin
            addr_d = {req_addr[31:2], 2'b00};
            if (req_we && req_size[1]) begin
              din_d   = req_wdata;
              state_d = ST_WRITE;
            end else begin
              state_d = ST_RD_WAIT;
            end
          end
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == LAST_CNT) begin
          if (we_q) begin
            din_d   = merged;
            state_d = ST_WRITE;
          end else begin
            rdata_d = load_val;
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    // Handshake and strobes are registered decodes of the next state, so they are glitch-free.
    ready_d = (state_d == ST_IDLE);
    wr_en_d = (state_d == ST_WRITE);
    done_d  = (state_d == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      lane_q     <= 2'b00;
      wdata_q    <= 32'd0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'd0;
      wr_en_q    <= 1'b0;
      addr_q     <= 32'd0;
      din_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
    end
  end

  assign req_ready    = ready_q;
  assign done         = done_q;
  assign err          = err_q;
  assign rdata        = rdata_q;
  assign Mem_WrEn     = wr_en_q;
  assign ALU_MEM_Addr = addr_q;
  assign MEM_DataIn   = din_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: word memory model, reference model feeding an expectation queue,
// and per-scenario tasks comparing completions popped from that queue.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
  localparam int LAT    = 1;
  localparam int BUDGET = 20;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic        Mem_WrEn;
  logic [31:0] ALU_MEM_Addr;
  logic [31:0] MEM_DataIn;
  logic [31:0] MEM_DataOut;

  mem_access_ctrl #(.MEM_RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .rdata(rdata),
    .err(err), .Mem_WrEn(Mem_WrEn), .ALU_MEM_Addr(ALU_MEM_Addr),
    .MEM_DataIn(MEM_DataIn), .MEM_DataOut(MEM_DataOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: data for an address is returned LAT-1 edges after the address appears.
  logic [31:0] mem [0:63];
  logic [5:0]  idx_dly [0:2];
  logic [5:0]  rd_idx;
  always @(posedge clk) begin
    if (Mem_WrEn) mem[ALU_MEM_Addr[7:2]] <= MEM_DataIn;
    idx_dly[0] <= ALU_MEM_Addr[7:2];
    idx_dly[1] <= idx_dly[0];
    idx_dly[2] <= idx_dly[1];
  end
  assign rd_idx      = (LAT == 1) ? ALU_MEM_Addr[7:2] : idx_dly[(LAT >= 2) ? LAT - 2 : 0];
  assign MEM_DataOut = mem[rd_idx];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          wr_cnt;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
  } exp_t;

  typedef struct {
    bit          timed_out;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          wr_cnt;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
  } obs_t;

  exp_t        exp_q [$];
  logic [31:0] model_mem [0:63];
  logic [31:0] model_rdata;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic req_t mk_req(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    r.we = we; r.size = size; r.uns = uns; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  function automatic bit model_mis(input logic [1:0] size, input logic [1:0] lo);
    return TRAP && (((size == 2'b01) && lo[0]) || (size[1] && (lo != 2'b00)));
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] size,
                                             input logic uns, input logic [1:0] lo);
    logic [31:0] v;
    if (size == 2'b00) begin
      v = (w >> (8 * lo)) & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'b01) begin
      v = (w >> (lo[1] ? 16 : 0)) & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] size,
                                              input logic [1:0] lo, input logic [31:0] wd);
    int          sh;
    logic [31:0] m;
    if (size == 2'b00) begin
      sh = 8 * int'(lo);
      m  = 32'h0000_00FF << sh;
    end else begin
      sh = lo[1] ? 16 : 0;
      m  = 32'h0000_FFFF << sh;
    end
    return (old & ~m) | ((wd << sh) & m);
  endfunction

  function automatic exp_t make_exp(input req_t r);
    exp_t       e;
    logic [5:0] idx;
    idx       = r.addr[7:2];
    e.wr_cnt  = 0;
    e.wr_addr = 32'd0;
    e.wr_data = 32'd0;
    e.err     = model_mis(r.size, r.addr[1:0]);
    if (e.err) begin
      e.lat = 1;
    end else if (r.we) begin
      e.wr_cnt  = 1;
      e.wr_addr = {r.addr[31:2], 2'b00};
      if (r.size[1]) begin
        e.lat     = 2;
        e.wr_data = r.wdata;
      end else begin
        e.lat     = LAT + 2;
        e.wr_data = model_store(model_mem[idx], r.size, r.addr[1:0], r.wdata);
      end
      model_mem[idx] = e.wr_data;
    end else begin
      e.lat       = LAT + 1;
      model_rdata = model_load(model_mem[idx], r.size, r.uns, r.addr[1:0]);
    end
    e.rdata = model_rdata;
    return e;
  endfunction

  task automatic drive(input req_t r);
    req_we       = r.we;
    req_size     = r.size;
    req_unsigned = r.uns;
    req_addr     = r.addr;
    req_wdata    = r.wdata;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_ready: req_ready=%b, required 1 within %0d cycles", req_ready, BUDGET);
    end
  endtask

  // Pushes the expected completion and drives the request through its accept edge.
  task automatic send_req(input req_t r);
    exp_q.push_back(make_exp(r));
    wait_ready();
    drive(r);
    req_valid = 1'b1;
    @(posedge clk);
  endtask

  // Watches from the accept edge until done; lat counts edges from accept to the done cycle.
  task automatic collect(input bit drop_valid, output obs_t o);
    o.timed_out = 1'b1;
    o.lat = 0; o.rdata = 32'd0; o.err = 1'b0;
    o.wr_cnt = 0; o.wr_addr = 32'd0; o.wr_data = 32'd0;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      if (k == 1 && drop_valid) req_valid = 1'b0;
      if (Mem_WrEn === 1'b1) begin
        o.wr_cnt++;
        o.wr_addr = ALU_MEM_Addr;
        o.wr_data = MEM_DataIn;
      end
      if (done === 1'b1) begin
        o.timed_out = 1'b0;
        o.lat   = k;
        o.rdata = rdata;
        o.err   = err;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    drive(mk_req(1'b0, 2'b00, 1'b0, 32'd0, 32'd0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset req_ready: got %b expected 1", req_ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset err: got %b expected 0", err); end
    n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset rdata: got %h expected 0", rdata); end
    n_checks++; if (Mem_WrEn !== 1'b0) begin n_fail++; $display("FAIL reset Mem_WrEn: got %b expected 0", Mem_WrEn); end
    n_checks++; if (ALU_MEM_Addr !== 32'd0) begin n_fail++; $display("FAIL reset ALU_MEM_Addr: got %h expected 0", ALU_MEM_Addr); end
    n_checks++; if (MEM_DataIn !== 32'd0) begin n_fail++; $display("FAIL reset MEM_DataIn: got %h expected 0", MEM_DataIn); end
    model_rdata = 32'd0;
    rst = 1'b0;
  endtask

  task automatic test_aligned_ops();
    req_t tbl [$];
    obs_t o;
    exp_t e;
    tbl.push_back(mk_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF));
    tbl.push_back(mk_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_0055));
    tbl.push_back(mk_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0));
    tbl.push_back(mk_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0));
    tbl.push_back(mk_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0));
    tbl.push_back(mk_req(1'b1, 2'b10, 1'b0, 32'h14, 32'h1234_5678));
    tbl.push_back(mk_req(1'b1, 2'b01, 1'b0, 32'h16, 32'hAAAA_CAFE));
    tbl.push_back(mk_req(1'b0, 2'b01, 1'b1, 32'h16, 32'h0));
    tbl.push_back(mk_req(1'b0, 2'b00, 1'b0, 32'h15, 32'h0));
    tbl.push_back(mk_req(1'b0, 2'b11, 1'b0, 32'h14, 32'h0));
    tbl.push_back(mk_req(1'b1, 2'b00, 1'b0, 32'h17, 32'hFFFF_FF80));
    tbl.push_back(mk_req(1'b0, 2'b00, 1'b0, 32'h17, 32'h0));
    for (int i = 0; i < tbl.size(); i++) begin
      send_req(tbl[i]);
      collect(1'b1, o);
      e = exp_q.pop_front();
      n_checks++;
      if (o.timed_out || o.lat !== e.lat) begin
        n_fail++; $display("FAIL op[%0d] latency: got %0d (timeout=%0b) expected %0d", i, o.lat, o.timed_out, e.lat);
      end
      n_checks++;
      if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL op[%0d] rdata: got %h expected %h", i, o.rdata, e.rdata); end
      n_checks++;
      if (o.err !== e.err) begin n_fail++; $display("FAIL op[%0d] err: got %b expected %b", i, o.err, e.err); end
      n_checks++;
      if (o.wr_cnt !== e.wr_cnt) begin n_fail++; $display("FAIL op[%0d] write count: got %0d expected %0d", i, o.wr_cnt, e.wr_cnt); end
      if (e.wr_cnt == 1) begin
        n_checks++;
        if (o.wr_addr !== e.wr_addr) begin n_fail++; $display("FAIL op[%0d] write addr: got %h expected %h", i, o.wr_addr, e.wr_addr); end
        n_checks++;
        if (o.wr_data !== e.wr_data) begin n_fail++; $display("FAIL op[%0d] write data: got %h expected %h", i, o.wr_data, e.wr_data); end
      end
    end
  endtask

  task automatic test_misaligned();
    req_t tbl [$];
    obs_t o;
    exp_t e;
    tbl.push_back(mk_req(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_7777));
    tbl.push_back(mk_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0));
    tbl.push_back(mk_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0));
    for (int i = 0; i < tbl.size(); i++) begin
      send_req(tbl[i]);
      collect(1'b1, o);
      e = exp_q.pop_front();
      n_checks++;
      if (o.timed_out || o.lat !== e.lat) begin
        n_fail++; $display("FAIL misalign[%0d] latency: got %0d (timeout=%0b) expected %0d", i, o.lat, o.timed_out, e.lat);
      end
      n_checks++;
      if (o.err !== e.err) begin n_fail++; $display("FAIL misalign[%0d] err: got %b expected %b", i, o.err, e.err); end
      n_checks++;
      if (o.wr_cnt !== e.wr_cnt) begin n_fail++; $display("FAIL misalign[%0d] write count: got %0d expected %0d", i, o.wr_cnt, e.wr_cnt); end
      n_checks++;
      if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL misalign[%0d] rdata: got %h expected %h", i, o.rdata, e.rdata); end
    end
    n_checks++;
    if (mem[4] !== model_mem[4]) begin n_fail++; $display("FAIL misalign memory word 0x10: got %h expected %h", mem[4], model_mem[4]); end
  endtask

  task automatic test_back_to_back();
    req_t r1, r2;
    obs_t o1, o2;
    exp_t e1, e2;
    r1 = mk_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    r2 = mk_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    exp_q.push_back(make_exp(r1));
    exp_q.push_back(make_exp(r2));
    wait_ready();
    drive(r1);
    req_valid = 1'b1;
    @(posedge clk);
    #1 drive(r2);
    collect(1'b0, o1);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b idle cycle: req_ready=%b done=%b, required 1 and 0", req_ready, done);
    end
    @(posedge clk);
    collect(1'b1, o2);
    e1 = exp_q.pop_front();
    e2 = exp_q.pop_front();
    n_checks++;
    if (o1.timed_out || o1.lat !== e1.lat) begin n_fail++; $display("FAIL b2b first latency: got %0d expected %0d", o1.lat, e1.lat); end
    n_checks++;
    if (o1.rdata !== e1.rdata) begin n_fail++; $display("FAIL b2b first rdata: got %h expected %h", o1.rdata, e1.rdata); end
    n_checks++;
    if (o2.timed_out || o2.lat !== e2.lat) begin n_fail++; $display("FAIL b2b second latency: got %0d expected %0d", o2.lat, e2.lat); end
    n_checks++;
    if (o2.rdata !== e2.rdata) begin n_fail++; $display("FAIL b2b second rdata: got %h expected %h", o2.rdata, e2.rdata); end
  endtask

  task automatic test_reset_mid_op();
    int strobes = 0;
    wait_ready();
    drive(mk_req(1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_0099));
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_rdata = 32'd0;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst-mid req_ready: got %b expected 1", req_ready); end
    n_checks++;
    if (Mem_WrEn !== 1'b0) begin n_fail++; $display("FAIL rst-mid Mem_WrEn: got %b expected 0", Mem_WrEn); end
    n_checks++;
    if (rdata !== model_rdata) begin n_fail++; $display("FAIL rst-mid rdata: got %h expected %h", rdata, model_rdata); end
    for (int k = 0; k < 6; k++) begin
      if (Mem_WrEn === 1'b1 || done === 1'b1) strobes++;
      @(negedge clk);
    end
    n_checks++;
    if (strobes != 0) begin n_fail++; $display("FAIL rst-mid strobes: got %0d Mem_WrEn/done cycles expected 0", strobes); end
    n_checks++;
    if (mem[4] !== model_mem[4]) begin n_fail++; $display("FAIL rst-mid memory word 0x10: got %h expected %h", mem[4], model_mem[4]); end
  endtask

  initial begin
    test_reset();
    test_aligned_ops();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
